mem_stage: RTL and testbench
============================

// Module: mem_stage
// PURPOSE
//  Memory-access pipeline stage; consumes the EX/MEM register (ALU result, store data, rd, ctrl)
//  and performs loads/stores over a valid/ready data-memory port. Loads are sign/zero-extended and
//  registered into the MEM/WB output; oWB_* doubles as the MEM forwarding source for EX.
//  Raises oStall to freeze IF..EX while an access is outstanding.
// PARAMETERS
//  RegWidth   32   datapath / address width (must be 32; byte lanes fixed at 4)
// PORTS
//  iClk          in   1   clock, all state on rising edge
//  iRst          in   1   synchronous reset, active-high
//  iFlush        in   1   kill op currently in stage (branch/trap redirect)
//  iEX_valid     in   1   EX/MEM register holds a valid instruction
//  iEX_mem_rd    in   1   op is a load
//  iEX_mem_wr    in   1   op is a store (never both with mem_rd)
//  iEX_reg_wr    in   1   op writes rd
//  iEX_func3     in   3   RV32 width/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  iEX_rd_addr   in   5   destination register
//  iEX_result    in   32  ALU result = effective address for ld/st, writeback value otherwise
//  iEX_st_data   in   32  rs2 value for stores
//  oStall        out  1   hold EX/MEM register and all upstream stages
//  oMem_req      out  1   request valid
//  oMem_we       out  1   1 = write
//  oMem_addr     out  32  word address {result[31:2],2'b00}
//  oMem_be       out  4   byte enables
//  oMem_wdata    out  32  lane-replicated store data
//  iMem_ready    in   1   request accepted this cycle when oMem_req&iMem_ready
//  iMem_rvalid   in   1   load data valid (>=1 cycle after accept, one per load, in order)
//  iMem_rdata    in   32  load word
//  oWB_valid     out  1   MEM/WB register valid
//  oWB_reg_wr    out  1   write rd
//  oWB_rd_addr   out  5   destination
//  oWB_data      out  32  writeback value
//  oMisaligned   out  1   misaligned-access exception, aligned with oWB_valid
// BEHAVIOUR
//  - Reset: state IDLE, all oWB_*/oMisaligned = 0; oMem_req/oStall = 0. Memory shares iRst, so no
//    stale response survives reset; reset mid-access abandons it immediately.
//  - memop = iEX_valid & (mem_rd|mem_wr) & aligned & !iFlush. Aligned: H needs addr[0]=0, W addr[1:0]=0.
//  - FSM: IDLE, WAIT_RSP, DRAIN.
//    IDLE: oMem_req = memop (combinational, inputs held stable by oStall). Store accepted -> complete
//      same cycle, stay IDLE. Load accepted -> WAIT_RSP. No accept -> stay, stall.
//    WAIT_RSP: oMem_req=0; iMem_rvalid -> load completes, ->IDLE; iFlush w/o rvalid -> DRAIN.
//    DRAIN: discard next rvalid, then ->IDLE; no request issued while in DRAIN.
//  - oStall = iEX_valid & (mem_rd|mem_wr) & aligned & !iFlush & !complete_this_cycle,
//    plus held in DRAIN when a memop waits. Non-mem and misaligned ops never stall.
//  - MEM/WB register (1-cycle latency) loads on every cycle where !oStall: valid=iEX_valid&!iFlush;
//    data = ext(load) for loads, iEX_result otherwise; reg_wr = iEX_reg_wr & !misaligned.
//    While oStall, oWB_valid=0 (bubble).
//  - Store: be = B 0001<<a[1:0], H 0011<<a[1:0], W 1111; wdata = B {4{d[7:0]}}, H {2{d[15:0]}}, W d.
//  - Load extract: byte lane a[1:0] / half a[1]; B,H sign-extend; BU,HU zero-extend; W as-is.
//  - Misaligned mem op: no request, no stall, oMisaligned=1 with oWB_valid=1, oWB_reg_wr=0.
//  - Flush in IDLE with request pending but not accepted: request dropped that cycle, no bubble hold.
//  - Illegal func3 (011,110,111) for ld/st: treated as W.
// TESTING
//  1. ADD rd=5 result=0x1234 -> next cycle oWB_valid=1 rd=5 data=0x00001234, oMem_req never high.
//  2. SB addr 0x103 data 0x..AB, ready=1 -> same cycle req,we=1 addr 0x100 be=1000 wdata 0xABABABAB, oStall=0.
//  3. LH addr 0x102, ready after 2 cycles, rvalid 3 cycles later rdata 0x8001_0000 -> oStall high
//     until rvalid cycle, next cycle WB data 0xFFFF8001; same with LHU -> 0x00008001.
//  4. LW addr 0x101 -> no req, no stall, next cycle oMisaligned=1 oWB_reg_wr=0.
//  5. LW accepted, iFlush in WAIT_RSP, new LW enters -> DRAIN swallows stale rvalid, new req starts
//     the cycle after, its data (not stale) reaches oWB_data.
//  6. iRst asserted in WAIT_RSP -> next cycle all outputs 0, IDLE; following ADD completes normally.

Source files
------------

// File: rtl/mem_stage_if.sv
// Bundle between the memory-access stage and its neighbours: EX/MEM register inputs,
// the valid/ready data-memory port, and the MEM/WB register outputs.
interface mem_stage_if #(
   parameter int unsigned RegWidth = 32
);
   logic                iFlush;
   logic                iEX_valid;
   logic                iEX_mem_rd;
   logic                iEX_mem_wr;
   logic                iEX_reg_wr;
   logic [2:0]          iEX_func3;
   logic [4:0]          iEX_rd_addr;
   logic [RegWidth-1:0] iEX_result;
   logic [RegWidth-1:0] iEX_st_data;
   logic                oStall;
   logic                oMem_req;
   logic                oMem_we;
   logic [RegWidth-1:0] oMem_addr;
   logic [3:0]          oMem_be;
   logic [RegWidth-1:0] oMem_wdata;
   logic                iMem_ready;
   logic                iMem_rvalid;
   logic [RegWidth-1:0] iMem_rdata;
   logic                oWB_valid;
   logic                oWB_reg_wr;
   logic [4:0]          oWB_rd_addr;
   logic [RegWidth-1:0] oWB_data;
   logic                oMisaligned;

   modport slave (
      input  iFlush, iEX_valid, iEX_mem_rd, iEX_mem_wr, iEX_reg_wr, iEX_func3, iEX_rd_addr,
             iEX_result, iEX_st_data, iMem_ready, iMem_rvalid, iMem_rdata,
      output oStall, oMem_req, oMem_we, oMem_addr, oMem_be, oMem_wdata,
             oWB_valid, oWB_reg_wr, oWB_rd_addr, oWB_data, oMisaligned
   );

   modport master (
      output iFlush, iEX_valid, iEX_mem_rd, iEX_mem_wr, iEX_reg_wr, iEX_func3, iEX_rd_addr,
             iEX_result, iEX_st_data, iMem_ready, iMem_rvalid, iMem_rdata,
      input  oStall, oMem_req, oMem_we, oMem_addr, oMem_be, oMem_wdata,
             oWB_valid, oWB_reg_wr, oWB_rd_addr, oWB_data, oMisaligned
   );
endinterface

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: issues loads/stores on a valid/ready port, extends load data
// and registers the MEM/WB result; stalls upstream while an access is outstanding.
module mem_stage #(
   parameter int unsigned RegWidth = 32
) (
   input logic       iClk,
   input logic       iRst,
   mem_stage_if.slave bus
);
   typedef enum logic [1:0] {IDLE, WAIT_RSP, DRAIN} state_e;

   state_e              state_q, state_d;
   logic                is_mem, aligned, misaligned, memop;
   logic                mem_req, complete, stall;
   logic [1:0]          lane;
   logic [3:0]          be;
   logic [RegWidth-1:0] wdata, ld_data;
   logic [7:0]          ld_byte;
   logic [15:0]         ld_half;

   logic                wb_valid_q, wb_valid_d;
   logic                wb_reg_wr_q, wb_reg_wr_d;
   logic                wb_mis_q, wb_mis_d;
   logic [4:0]          wb_rd_q, wb_rd_d;
   logic [RegWidth-1:0] wb_data_q, wb_data_d;

   // func3[1:0] selects width; illegal encodings fall into the word case
   always_comb begin
      lane   = bus.iEX_result[1:0];
      is_mem = bus.iEX_valid & (bus.iEX_mem_rd | bus.iEX_mem_wr);
      case (bus.iEX_func3[1:0])
         2'b00: begin
            aligned = 1'b1;
            be      = 4'b0001 << lane;
            wdata   = {4{bus.iEX_st_data[7:0]}};
         end
         2'b01: begin
            aligned = ~lane[0];
            be      = 4'b0011 << lane;
            wdata   = {2{bus.iEX_st_data[15:0]}};
         end
         default: begin
            aligned = (lane == 2'b00);
            be      = 4'b1111;
            wdata   = bus.iEX_st_data;
         end
      endcase
      misaligned = is_mem & ~aligned;
      memop      = is_mem & aligned & ~bus.iFlush;
   end

   always_comb begin
      ld_byte = bus.iMem_rdata[{lane, 3'b000} +: 8];
      ld_half = lane[1] ? bus.iMem_rdata[31:16] : bus.iMem_rdata[15:0];
      case (bus.iEX_func3)
         3'b000:  ld_data = {{(RegWidth-8){ld_byte[7]}}, ld_byte};
         3'b001:  ld_data = {{(RegWidth-16){ld_half[15]}}, ld_half};
         3'b100:  ld_data = {{(RegWidth-8){1'b0}}, ld_byte};
         3'b101:  ld_data = {{(RegWidth-16){1'b0}}, ld_half};
         default: ld_data = bus.iMem_rdata;
      endcase
   end

   always_comb begin
      state_d  = state_q;
      mem_req  = 1'b0;
      complete = 1'b0;
      case (state_q)
         IDLE: begin
            mem_req = memop;
            if (memop && bus.iMem_ready) begin
               if (bus.iEX_mem_wr) complete = 1'b1;
               else                state_d  = WAIT_RSP;
            end
         end
         WAIT_RSP: begin
            if (bus.iMem_rvalid) begin
               complete = 1'b1;
               state_d  = IDLE;
            end else if (bus.iFlush) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (bus.iMem_rvalid) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // reset gating keeps req/stall low even if EX still presents a memop
      stall = memop & ~complete & ~iRst;
   end

   always_comb begin
      wb_valid_d  = 1'b0;
      wb_reg_wr_d = 1'b0;
      wb_mis_d    = 1'b0;
      wb_rd_d     = wb_rd_q;
      wb_data_d   = wb_data_q;
      if (!stall) begin
         wb_valid_d  = bus.iEX_valid & ~bus.iFlush;
         wb_reg_wr_d = wb_valid_d & bus.iEX_reg_wr & ~misaligned;
         wb_mis_d    = wb_valid_d & misaligned;
         wb_rd_d     = bus.iEX_rd_addr;
         wb_data_d   = (bus.iEX_mem_rd & ~misaligned) ? ld_data : bus.iEX_result;
      end
   end

   always_ff @(posedge iClk) begin
      if (iRst) begin
         state_q     <= IDLE;
         wb_valid_q  <= 1'b0;
         wb_reg_wr_q <= 1'b0;
         wb_mis_q    <= 1'b0;
         wb_rd_q     <= '0;
         wb_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         wb_valid_q  <= wb_valid_d;
         wb_reg_wr_q <= wb_reg_wr_d;
         wb_mis_q    <= wb_mis_d;
         wb_rd_q     <= wb_rd_d;
         wb_data_q   <= wb_data_d;
      end
   end

   assign bus.oStall      = stall;
   assign bus.oMem_req    = mem_req & ~iRst;
   assign bus.oMem_we     = bus.iEX_mem_wr;
   assign bus.oMem_addr   = {bus.iEX_result[RegWidth-1:2], 2'b00};
   assign bus.oMem_be     = be;
   assign bus.oMem_wdata  = wdata;
   assign bus.oWB_valid   = wb_valid_q;
   assign bus.oWB_reg_wr  = wb_reg_wr_q;
   assign bus.oWB_rd_addr = wb_rd_q;
   assign bus.oWB_data    = wb_data_q;
   assign bus.oMisaligned = wb_mis_q;
endmodule

// File: tb/tb_mem_stage.sv
// Scenario bench for mem_stage: expected MEM/WB entries are queued as stimulus is driven and
// popped when the writeback should appear; memory-port outputs are checked cycle by cycle.
module tb_mem_stage;
   typedef struct packed {
      logic        v;
      logic        rw;
      logic [4:0]  rd;
      logic [31:0] data;
      logic        mis;
   } wb_t;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   mem_stage_if #(.RegWidth(32)) bus ();
   mem_stage #(.RegWidth(32)) dut (.iClk(clk), .iRst(rst), .bus(bus));

   wb_t sb[$];
   wb_t exp_w, act_w;
   int  n_tests = 0;
   int  n_fail  = 0;

   logic [2:0]  st_f3   [3] = '{3'b000, 3'b001, 3'b010};
   logic [31:0] st_ad   [3] = '{32'h103, 32'h102, 32'h200};
   logic [31:0] st_dat  [3] = '{32'h123456AB, 32'h1234BEEF, 32'hCAFEF00D};
   logic [31:0] st_exa  [3] = '{32'h100, 32'h100, 32'h200};
   logic [3:0]  st_be   [3] = '{4'b1000, 4'b1100, 4'b1111};
   logic [31:0] st_wd   [3] = '{32'hABABABAB, 32'hBEEFBEEF, 32'hCAFEF00D};

   logic [2:0]  ld_f3   [6] = '{3'b001, 3'b101, 3'b000, 3'b100, 3'b010, 3'b011};
   logic [31:0] ld_ad   [6] = '{32'h102, 32'h102, 32'h101, 32'h103, 32'h104, 32'h108};
   logic [4:0]  ld_rd   [6] = '{5'd7, 5'd7, 5'd8, 5'd9, 5'd10, 5'd11};
   int          ld_rdy  [6] = '{2, 2, 0, 1, 0, 1};
   int          ld_rsp  [6] = '{3, 3, 1, 2, 1, 2};
   logic [31:0] ld_mem  [6] = '{32'h80010000, 32'h80010000, 32'h00008000, 32'hF1000000,
                               32'h89ABCDEF, 32'h7E000080};
   logic [31:0] ld_exp  [6] = '{32'hFFFF8001, 32'h00008001, 32'hFFFFFF80, 32'h000000F1,
                               32'h89ABCDEF, 32'h7E000080};

   logic        ms_ld   [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
   logic [2:0]  ms_f3   [4] = '{3'b010, 3'b001, 3'b001, 3'b010};
   logic [31:0] ms_ad   [4] = '{32'h101, 32'h103, 32'h101, 32'h102};

   function automatic wb_t wb_now();
      return {bus.oWB_valid, bus.oWB_reg_wr, bus.oWB_rd_addr, bus.oWB_data, bus.oMisaligned};
   endfunction

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ex(input logic v, input logic ld, input logic st, input logic rw,
                         input logic [2:0] f3, input logic [4:0] rd, input logic [31:0] res,
                         input logic [31:0] sd);
      bus.iEX_valid   = v;
      bus.iEX_mem_rd  = ld;
      bus.iEX_mem_wr  = st;
      bus.iEX_reg_wr  = rw;
      bus.iEX_func3   = f3;
      bus.iEX_rd_addr = rd;
      bus.iEX_result  = res;
      bus.iEX_st_data = sd;
   endtask

   task automatic clear_ex();
      set_ex(1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 5'd0, 32'h0, 32'h0);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.iFlush = 1'b0; bus.iMem_ready = 1'b0; bus.iMem_rvalid = 1'b0; bus.iMem_rdata = '0;
      clear_ex();
      repeat (2) cyc();
      @(negedge clk);
      n_tests++;
      if ({wb_now(), bus.oMem_req, bus.oStall} !== '0) begin
         n_fail++;
         $display("FAIL reset_state: got wb=%h req=%b stall=%b expected all zero",
                  wb_now(), bus.oMem_req, bus.oStall);
      end
      cyc();
      rst = 1'b0;
   endtask

   task automatic test_alu();
      cyc();
      set_ex(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 5'd5, 32'h1234, 32'h0);
      sb.push_back(wb_t'{1'b1, 1'b1, 5'd5, 32'h00001234, 1'b0});
      @(negedge clk);
      n_tests++;
      if ({bus.oMem_req, bus.oStall} !== 2'b00) begin
         n_fail++;
         $display("FAIL alu_no_req: got req/stall=%b expected 00", {bus.oMem_req, bus.oStall});
      end
      cyc();
      set_ex(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 5'd8, 32'h77, 32'h0);
      bus.iFlush = 1'b1;
      @(negedge clk);
      n_tests++;
      exp_w = sb.pop_front();
      act_w = wb_now();
      if (act_w !== exp_w || bus.oMem_req !== 1'b0) begin
         n_fail++;
         $display("FAIL alu_wb: got %h req=%b expected %h req=0", act_w, bus.oMem_req, exp_w);
      end
      cyc();
      clear_ex();
      bus.iFlush = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.oWB_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL alu_flushed: got wb_valid=%b expected 0", bus.oWB_valid);
      end
   endtask

   task automatic test_store();
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin
            cyc();
            set_ex(1'b1, 1'b0, 1'b1, 1'b0, st_f3[i], 5'd0, st_ad[i], st_dat[i]);
            bus.iMem_ready = 1'b0;
            @(negedge clk);
            n_tests++;
            if ({bus.oMem_req, bus.oStall, bus.oWB_valid} !== 3'b110) begin
               n_fail++;
               $display("FAIL store_wait: got req/stall/wbv=%b expected 110",
                        {bus.oMem_req, bus.oStall, bus.oWB_valid});
            end
         end
         cyc();
         set_ex(1'b1, 1'b0, 1'b1, 1'b0, st_f3[i], 5'd0, st_ad[i], st_dat[i]);
         bus.iMem_ready = 1'b1;
         sb.push_back(wb_t'{1'b1, 1'b0, 5'd0, st_ad[i], 1'b0});
         @(negedge clk);
         n_tests++;
         if ({bus.oMem_req, bus.oMem_we, bus.oMem_addr, bus.oMem_be, bus.oMem_wdata, bus.oStall}
             !== {1'b1, 1'b1, st_exa[i], st_be[i], st_wd[i], 1'b0}) begin
            n_fail++;
            $display("FAIL store_port[%0d]: got req=%b we=%b addr=%h be=%b wdata=%h stall=%b expected 1 1 %h %b %h 0",
                     i, bus.oMem_req, bus.oMem_we, bus.oMem_addr, bus.oMem_be, bus.oMem_wdata,
                     bus.oStall, st_exa[i], st_be[i], st_wd[i]);
         end
         cyc();
         clear_ex();
         bus.iMem_ready = 1'b0;
         @(negedge clk);
         n_tests++;
         exp_w = sb.pop_front();
         act_w = wb_now();
         if (act_w !== exp_w) begin
            n_fail++;
            $display("FAIL store_wb[%0d]: got %h expected %h", i, act_w, exp_w);
         end
      end
   endtask

   task automatic test_load();
      for (int i = 0; i < 6; i++) begin
         for (int k = 0; k <= ld_rdy[i]; k++) begin
            cyc();
            set_ex(1'b1, 1'b1, 1'b0, 1'b1, ld_f3[i], ld_rd[i], ld_ad[i], 32'h0);
            bus.iMem_ready = (k == ld_rdy[i]);
            @(negedge clk);
            n_tests++;
            if ({bus.oMem_req, bus.oMem_we, bus.oMem_addr, bus.oStall, bus.oWB_valid}
                !== {1'b1, 1'b0, {ld_ad[i][31:2], 2'b00}, 1'b1, 1'b0}) begin
               n_fail++;
               $display("FAIL load_req[%0d.%0d]: got req=%b we=%b addr=%h stall=%b wbv=%b expected 1 0 %h 1 0",
                        i, k, bus.oMem_req, bus.oMem_we, bus.oMem_addr, bus.oStall, bus.oWB_valid,
                        {ld_ad[i][31:2], 2'b00});
            end
         end
         for (int j = 1; j <= ld_rsp[i]; j++) begin
            cyc();
            bus.iMem_ready  = 1'b0;
            bus.iMem_rvalid = (j == ld_rsp[i]);
            bus.iMem_rdata  = ld_mem[i];
            if (j == ld_rsp[i]) sb.push_back(wb_t'{1'b1, 1'b1, ld_rd[i], ld_exp[i], 1'b0});
            @(negedge clk);
            n_tests++;
            if ({bus.oMem_req, bus.oStall, bus.oWB_valid} !== {1'b0, (j != ld_rsp[i]), 1'b0}) begin
               n_fail++;
               $display("FAIL load_wait[%0d.%0d]: got req/stall/wbv=%b expected 0%b0",
                        i, j, {bus.oMem_req, bus.oStall, bus.oWB_valid}, (j != ld_rsp[i]));
            end
         end
         cyc();
         clear_ex();
         bus.iMem_rvalid = 1'b0;
         @(negedge clk);
         n_tests++;
         exp_w = sb.pop_front();
         act_w = wb_now();
         if (act_w !== exp_w) begin
            n_fail++;
            $display("FAIL load_wb[%0d]: got %h expected %h", i, act_w, exp_w);
         end
      end
   endtask

   task automatic test_misaligned();
      for (int i = 0; i < 4; i++) begin
         cyc();
         set_ex(1'b1, ms_ld[i], ~ms_ld[i], ms_ld[i], ms_f3[i], 5'(20 + i), ms_ad[i], 32'h0);
         bus.iMem_ready = 1'b1;
         sb.push_back(wb_t'{1'b1, 1'b0, 5'(20 + i), 32'h0, 1'b1});
         @(negedge clk);
         n_tests++;
         if ({bus.oMem_req, bus.oStall} !== 2'b00) begin
            n_fail++;
            $display("FAIL misaligned_port[%0d]: got req/stall=%b expected 00", i,
                     {bus.oMem_req, bus.oStall});
         end
         cyc();
         clear_ex();
         bus.iMem_ready = 1'b0;
         @(negedge clk);
         n_tests++;
         exp_w = sb.pop_front();
         act_w = wb_now();
         act_w.data = '0;
         if (act_w !== exp_w) begin
            n_fail++;
            $display("FAIL misaligned_wb[%0d]: got %h expected %h (data ignored)", i, act_w, exp_w);
         end
      end
   endtask

   task automatic test_flush_drain();
      cyc();
      set_ex(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 5'd3, 32'h200, 32'h0);
      bus.iMem_ready = 1'b0;
      bus.iFlush     = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({bus.oMem_req, bus.oStall} !== 2'b00) begin
         n_fail++;
         $display("FAIL flush_idle: got req/stall=%b expected 00", {bus.oMem_req, bus.oStall});
      end
      cyc();
      clear_ex();
      bus.iFlush = 1'b0;
      @(negedge clk);
      n_tests++;
      if (bus.oWB_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_idle_wb: got wb_valid=%b expected 0", bus.oWB_valid);
      end
      cyc();
      set_ex(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 5'd3, 32'h200, 32'h0);
      bus.iMem_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({bus.oMem_req, bus.oStall} !== 2'b11) begin
         n_fail++;
         $display("FAIL drain_accept: got req/stall=%b expected 11", {bus.oMem_req, bus.oStall});
      end
      cyc();
      bus.iMem_ready = 1'b0;
      bus.iFlush     = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({bus.oMem_req, bus.oStall, bus.oWB_valid} !== 3'b000) begin
         n_fail++;
         $display("FAIL drain_flush: got req/stall/wbv=%b expected 000",
                  {bus.oMem_req, bus.oStall, bus.oWB_valid});
      end
      cyc();
      bus.iFlush = 1'b0;
      set_ex(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 5'd4, 32'h300, 32'h0);
      bus.iMem_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({bus.oMem_req, bus.oStall, bus.oWB_valid} !== 3'b010) begin
         n_fail++;
         $display("FAIL drain_hold: got req/stall/wbv=%b expected 010",
                  {bus.oMem_req, bus.oStall, bus.oWB_valid});
      end
      cyc();
      bus.iMem_rvalid = 1'b1;
      bus.iMem_rdata  = 32'hDEAD0000;
      @(negedge clk);
      n_tests++;
      if ({bus.oMem_req, bus.oStall, bus.oWB_valid} !== 3'b010) begin
         n_fail++;
         $display("FAIL drain_stale: got req/stall/wbv=%b expected 010",
                  {bus.oMem_req, bus.oStall, bus.oWB_valid});
      end
      cyc();
      bus.iMem_rvalid = 1'b0;
      @(negedge clk);
      n_tests++;
      if ({bus.oMem_req, bus.oStall, bus.oMem_addr} !== {2'b11, 32'h300}) begin
         n_fail++;
         $display("FAIL drain_reissue: got req=%b stall=%b addr=%h expected 1 1 00000300",
                  bus.oMem_req, bus.oStall, bus.oMem_addr);
      end
      cyc();
      bus.iMem_ready  = 1'b0;
      bus.iMem_rvalid = 1'b1;
      bus.iMem_rdata  = 32'h12345678;
      sb.push_back(wb_t'{1'b1, 1'b1, 5'd4, 32'h12345678, 1'b0});
      @(negedge clk);
      n_tests++;
      if ({bus.oMem_req, bus.oStall} !== 2'b00) begin
         n_fail++;
         $display("FAIL drain_rsp: got req/stall=%b expected 00", {bus.oMem_req, bus.oStall});
      end
      cyc();
      clear_ex();
      bus.iMem_rvalid = 1'b0;
      @(negedge clk);
      n_tests++;
      exp_w = sb.pop_front();
      act_w = wb_now();
      if (act_w !== exp_w) begin
         n_fail++;
         $display("FAIL drain_wb: got %h expected %h", act_w, exp_w);
      end
   endtask

   task automatic test_reset_mid();
      cyc();
      set_ex(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 5'd12, 32'h400, 32'h0);
      bus.iMem_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({bus.oMem_req, bus.oStall} !== 2'b11) begin
         n_fail++;
         $display("FAIL rstmid_accept: got req/stall=%b expected 11", {bus.oMem_req, bus.oStall});
      end
      cyc();
      bus.iMem_ready = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      n_tests++;
      if ({bus.oMem_req, bus.oStall} !== 2'b00) begin
         n_fail++;
         $display("FAIL rstmid_during: got req/stall=%b expected 00", {bus.oMem_req, bus.oStall});
      end
      cyc();
      rst = 1'b0;
      clear_ex();
      @(negedge clk);
      n_tests++;
      if ({wb_now(), bus.oMem_req, bus.oStall} !== '0) begin
         n_fail++;
         $display("FAIL rstmid_after: got wb=%h req=%b stall=%b expected all zero",
                  wb_now(), bus.oMem_req, bus.oStall);
      end
      cyc();
      set_ex(1'b1, 1'b0, 1'b0, 1'b1, 3'b000, 5'd6, 32'h55, 32'h0);
      sb.push_back(wb_t'{1'b1, 1'b1, 5'd6, 32'h55, 1'b0});
      @(negedge clk);
      n_tests++;
      if ({bus.oMem_req, bus.oStall} !== 2'b00) begin
         n_fail++;
         $display("FAIL rstmid_add: got req/stall=%b expected 00", {bus.oMem_req, bus.oStall});
      end
      cyc();
      set_ex(1'b1, 1'b1, 1'b0, 1'b1, 3'b010, 5'd13, 32'h404, 32'h0);
      bus.iMem_ready = 1'b1;
      @(negedge clk);
      n_tests++;
      exp_w = sb.pop_front();
      act_w = wb_now();
      if (act_w !== exp_w || {bus.oMem_req, bus.oStall} !== 2'b11) begin
         n_fail++;
         $display("FAIL rstmid_add_wb: got %h req/stall=%b expected %h 11", act_w,
                  {bus.oMem_req, bus.oStall}, exp_w);
      end
      cyc();
      bus.iMem_ready  = 1'b0;
      bus.iMem_rvalid = 1'b1;
      bus.iMem_rdata  = 32'hA5A50001;
      sb.push_back(wb_t'{1'b1, 1'b1, 5'd13, 32'hA5A50001, 1'b0});
      @(negedge clk);
      n_tests++;
      if (bus.oStall !== 1'b0) begin
         n_fail++;
         $display("FAIL rstmid_ld_rsp: got stall=%b expected 0", bus.oStall);
      end
      cyc();
      clear_ex();
      bus.iMem_rvalid = 1'b0;
      @(negedge clk);
      n_tests++;
      exp_w = sb.pop_front();
      act_w = wb_now();
      if (act_w !== exp_w) begin
         n_fail++;
         $display("FAIL rstmid_ld_wb: got %h expected %h", act_w, exp_w);
      end
   endtask

   initial begin
      test_reset();
      test_alu();
      test_store();
      test_load();
      test_misaligned();
      test_flush_drain();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got still running expected finished");
      $fatal(1);
   end
endmodule
